axis_stim_src: RTL and testbench



---
 rtl/axis_stim_src.sv | 173 +++++++++++++++++
 tb/tb_axis_stim_src.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stim_src.sv
// AXI4-Stream stimulus master: emits one packet of NUM_OF_SAMPLES beats per
// START pulse (ramp, 16-bit Galois LFSR or impulse), TLAST on the final beat,
// optional idle gaps between beats, DONE pulse and packet counter.
//
// Ports
//   M_AXIS_ACLK     clock
//   M_AXIS_ARESETN  synchronous active-low reset
//   START           packet request, sampled only while idle
//   MODE            00 ramp, 01 LFSR, 10 impulse, 11 ramp
//   SEED            pattern seed / impulse amplitude
//   BUSY            high from packet launch through the DONE cycle
//   DONE            one-cycle pulse after the last beat is accepted
//   PKT_COUNT       completed packets (wraps)
//   M_AXIS_TREADY   sink ready
//   M_AXIS_TDATA    sample
//   M_AXIS_TLAST    final beat marker
//   M_AXIS_TVALID   beat valid
module axis_stim_src #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned NUM_OF_SAMPLES = 500,
    parameter int unsigned GAP_CYCLES     = 0
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  START,
    input  logic [1:0]            MODE,
    input  logic [DATA_WIDTH-1:0] SEED,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           PKT_COUNT,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID
);

    localparam int unsigned BEAT_W    = (NUM_OF_SAMPLES > 1) ? $clog2(NUM_OF_SAMPLES) : 1;
    localparam int unsigned LAST_BEAT = NUM_OF_SAMPLES - 1;
    localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t                  state_q;
    logic [1:0]              mode_q;
    logic [15:0]             lfsr_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [GAP_W-1:0]        gap_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             pkt_q;

    logic [15:0]             seed16_c;
    logic [15:0]             lfsr_seed_c;
    logic [15:0]             lfsr_next_c;
    logic [DATA_WIDTH-1:0]   first_data_c;
    logic [DATA_WIDTH-1:0]   next_data_c;
    logic                    accept_c;
    logic                    last_beat_c;
    logic                    next_is_last_c;

    // Pattern generation: beat-0 value from the live inputs, successor values
    // from the latched mode and current beat.
    always_comb begin
        seed16_c       = 16'(SEED);
        // An all-zero LFSR state would lock up, so zero seeds start at 1.
        lfsr_seed_c    = (seed16_c == 16'h0000) ? 16'h0001 : seed16_c;
        lfsr_next_c    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        first_data_c   = SEED;
        next_data_c    = tdata_q + DATA_WIDTH'(1);
        accept_c       = tvalid_q & M_AXIS_TREADY;
        last_beat_c    = (beat_q == BEAT_W'(LAST_BEAT));
        next_is_last_c = ((beat_q + BEAT_W'(1)) == BEAT_W'(LAST_BEAT));

        if (MODE == 2'b01) begin
            first_data_c = DATA_WIDTH'(lfsr_seed_c);
        end

        case (mode_q)
            2'b01:   next_data_c = DATA_WIDTH'(lfsr_next_c);
            2'b10:   next_data_c = '0;
            default: next_data_c = tdata_q + DATA_WIDTH'(1);
        endcase
    end

    // Packet sequencer with registered stream and status outputs.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            lfsr_q   <= 16'h0000;
            beat_q   <= '0;
            gap_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pkt_q    <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q  <= S_SEND;
                        mode_q   <= MODE;
                        lfsr_q   <= lfsr_seed_c;
                        tdata_q  <= first_data_c;
                        beat_q   <= '0;
                        gap_q    <= '0;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (LAST_BEAT == 0);
                        busy_q   <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (accept_c) begin
                        if (last_beat_c) begin
                            state_q  <= S_FIN;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            // Count and DONE become visible together in the FIN cycle.
                            done_q   <= 1'b1;
                            pkt_q    <= pkt_q + 16'd1;
                        end else begin
                            beat_q  <= beat_q + BEAT_W'(1);
                            lfsr_q  <= lfsr_next_c;
                            tdata_q <= next_data_c;
                            tlast_q <= next_is_last_c;
                            if (GAP_CYCLES != 0) begin
                                state_q  <= S_GAP;
                                tvalid_q <= 1'b0;
                                gap_q    <= '0;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_LAST)) begin
                        state_q  <= S_SEND;
                        tvalid_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign PKT_COUNT     = pkt_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;

endmodule

// File: tb/tb_axis_stim_src.sv
// Bench for axis_stim_src: three instances (4 beats no gap, 3 beats with
// 2-cycle gaps, 1 beat) driven from a packet table; a scoreboard queue holds
// the expected beats and a negedge monitor pops and compares accepted beats.
module tb_axis_stim_src;

    logic        clk;
    logic        rst_n;
    logic        tready;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic        start  [3];
    logic        busy   [3];
    logic        done   [3];
    logic [15:0] pkt    [3];
    logic [15:0] tdata  [3];
    logic        tlast  [3];
    logic        tvalid [3];

    int nsamp [3] = '{4, 3, 1};
    int gapc  [3] = '{0, 2, 0};

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        int               inst;
        logic [1:0]       mode;
        logic [15:0]      seed;
        bit               rnd;
        bit               hold;
        logic [3:0][15:0] exp;
    } row_t;

    beat_t       exp_q[$];
    row_t        rows[8];
    logic [15:0] exp_pkt [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   sel     = 0;
    int   beat_idx = 0;
    bit   rnd_rdy  = 0;
    bit   rdy_hold = 0;

    // monitor state
    bit          prev_stall = 0;
    logic [15:0] p_data;
    logic        p_last;
    int          low_run  = 0;
    int          last_gap = 0;
    bit          in_pkt   = 0;

    axis_stim_src #(.DATA_WIDTH(16), .NUM_OF_SAMPLES(4), .GAP_CYCLES(0)) u_a (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start[0]), .MODE(mode),
        .SEED(seed), .BUSY(busy[0]), .DONE(done[0]), .PKT_COUNT(pkt[0]),
        .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata[0]), .M_AXIS_TLAST(tlast[0]),
        .M_AXIS_TVALID(tvalid[0]));

    axis_stim_src #(.DATA_WIDTH(16), .NUM_OF_SAMPLES(3), .GAP_CYCLES(2)) u_b (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start[1]), .MODE(mode),
        .SEED(seed), .BUSY(busy[1]), .DONE(done[1]), .PKT_COUNT(pkt[1]),
        .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata[1]), .M_AXIS_TLAST(tlast[1]),
        .M_AXIS_TVALID(tvalid[1]));

    axis_stim_src #(.DATA_WIDTH(16), .NUM_OF_SAMPLES(1), .GAP_CYCLES(0)) u_c (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start[2]), .MODE(mode),
        .SEED(seed), .BUSY(busy[2]), .DONE(done[2]), .PKT_COUNT(pkt[2]),
        .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata[2]), .M_AXIS_TLAST(tlast[2]),
        .M_AXIS_TVALID(tvalid[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic row_t mk(input int inst, input logic [1:0] m, input logic [15:0] s,
                                input bit rnd, input bit hold,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        row_t r;
        r.inst = inst; r.mode = m; r.seed = s; r.rnd = rnd; r.hold = hold;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
        return r;
    endfunction

    // TREADY driver, updated just after each rising edge
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_hold)     tready = 1'b0;
            else if (rnd_rdy) tready = 1'($urandom_range(0, 1));
            else              tready = 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, gap length, BUSY during gaps
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            low_run    = 0;
            last_gap   = 0;
            in_pkt     = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(tvalid[sel]), 32'(1'b1));
                chk("stall_data",  32'(tdata[sel]),  32'(p_data));
                chk("stall_last",  32'(tlast[sel]),  32'(p_last));
            end
            if (tvalid[sel]) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end else begin
                low_run++;
                if (in_pkt) chk("busy_in_gap", 32'(busy[sel]), 32'(1'b1));
            end
            if (tvalid[sel] && tready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(tdata[sel]), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(tdata[sel]), 32'(e.d));
                    chk("beat_last", 32'(tlast[sel]), 32'(e.l));
                end
                if (beat_idx > 0 && gapc[sel] > 0)
                    chk("gap_len", 32'(last_gap), 32'(gapc[sel]));
                last_gap = 0;
                in_pkt   = !tlast[sel];
                beat_idx++;
            end
            prev_stall = tvalid[sel] && !tready;
            p_data     = tdata[sel];
            p_last     = tlast[sel];
        end
    end

    task automatic run_row(input row_t r);
        int n;
        int cyc;
        n        = nsamp[r.inst];
        sel      = r.inst;
        beat_idx = 0;
        for (int k = 0; k < n; k++) exp_q.push_back('{d: r.exp[k], l: (k == n - 1)});
        rnd_rdy = r.rnd;
        @(posedge clk); #1;
        mode = r.mode; seed = r.seed; start[sel] = 1'b1;
        @(posedge clk); #1;
        if (!r.hold) start[sel] = 1'b0;
        @(negedge clk);
        chk("start_latency", 32'(tvalid[sel]), 32'(1'b1));
        chk("busy_start",    32'(busy[sel]),   32'(1'b1));
        cyc = 1;
        while (done[sel] !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        start[sel] = 1'b0;
        chk("done_seen", 32'(done[sel]), 32'(1'b1));
        exp_pkt[sel] = exp_pkt[sel] + 16'd1;
        chk("pkt_count", 32'(pkt[sel]),  32'(exp_pkt[sel]));
        chk("busy_fin",  32'(busy[sel]), 32'(1'b1));
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        if (!r.rnd) chk("pkt_cycles", 32'(cyc), 32'(n + 1 + gapc[sel] * (n - 1)));
        @(negedge clk);
        chk("done_pulse", 32'(done[sel]),   32'(1'b0));
        chk("busy_idle",  32'(busy[sel]),   32'(1'b0));
        chk("valid_idle", 32'(tvalid[sel]), 32'(1'b0));
        rnd_rdy = 1'b0;
        exp_q.delete();
        if (r.hold) begin
            repeat (3) @(negedge clk);
            chk("no_requeue_valid", 32'(tvalid[sel]), 32'(1'b0));
            chk("no_requeue_busy",  32'(busy[sel]),   32'(1'b0));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rows[0] = mk(0, 2'b00, 16'hFFFE, 0, 0, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001);
        rows[1] = mk(0, 2'b01, 16'h0000, 0, 0, 16'h0001, 16'hB400, 16'h5A00, 16'h2D00);
        rows[2] = mk(0, 2'b00, 16'h1234, 1, 1, 16'h1234, 16'h1235, 16'h1236, 16'h1237);
        rows[3] = mk(0, 2'b10, 16'h4000, 0, 0, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
        rows[4] = mk(0, 2'b11, 16'h00FF, 1, 0, 16'h00FF, 16'h0100, 16'h0101, 16'h0102);
        rows[5] = mk(1, 2'b01, 16'h0000, 1, 0, 16'h0001, 16'hB400, 16'h5A00, 16'h0000);
        rows[6] = mk(1, 2'b10, 16'h4000, 0, 0, 16'h4000, 16'h0000, 16'h0000, 16'h0000);
        rows[7] = mk(2, 2'b00, 16'h00AA, 0, 1, 16'h00AA, 16'h0000, 16'h0000, 16'h0000);

        rst_n = 1'b0;
        mode  = 2'b00;
        seed  = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            start[i]   = 1'b0;
            exp_pkt[i] = 16'h0000;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(tvalid[0]), 32'(1'b0));
        chk("rst_last",  32'(tlast[0]),  32'(1'b0));
        chk("rst_data",  32'(tdata[0]),  32'd0);
        chk("rst_busy",  32'(busy[0]),   32'(1'b0));
        chk("rst_done",  32'(done[0]),   32'(1'b0));
        chk("rst_pkt",   32'(pkt[0]),    32'd0);
        chk("rst_valid_b", 32'(tvalid[1]), 32'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_row(rows[i]);

        // Reset while beat 2 of a ramp packet is being presented
        sel = 0; beat_idx = 0; rnd_rdy = 1'b0;
        exp_q.push_back('{d: 16'h0100, l: 1'b0});
        exp_q.push_back('{d: 16'h0101, l: 1'b0});
        @(posedge clk); #1;
        mode = 2'b00; seed = 16'h0100; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rdy_hold = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_beat2", 32'(tdata[0]), 32'h0102);
        @(negedge clk);
        chk("rst_mid_valid", 32'(tvalid[0]), 32'(1'b0));
        chk("rst_mid_last",  32'(tlast[0]),  32'(1'b0));
        chk("rst_mid_busy",  32'(busy[0]),   32'(1'b0));
        chk("rst_mid_done",  32'(done[0]),   32'(1'b0));
        chk("rst_mid_pkt",   32'(pkt[0]),    32'd0);
        chk("rst_mid_pkt_b", 32'(pkt[1]),    32'd0);
        chk("rst_mid_beats", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) exp_pkt[i] = 16'h0000;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        rdy_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", 32'(done[0]), 32'(1'b0));

        run_row(mk(0, 2'b00, 16'h0010, 0, 0, 16'h0010, 16'h0011, 16'h0012, 16'h0013));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
